// File: rtl/mult_feeder.sv
// mult_feeder: operand FIFO and sequencer in front of a signed shift-add multiplier.
// Optional watchdog on the WAIT state is enabled by defining MULT_FEEDER_TIMEOUT_EN.
module mult_feeder #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int TMO   = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_A,
  input  logic [W-1:0]   in_B,
  output logic           mult_start,
  output logic [W-1:0]   mult_A,
  output logic [W-1:0]   mult_B,
  input  logic           mult_done,
  input  logic [2*W-1:0] mult_out,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*W-1:0] res_data,
  output logic           err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [W-1:0]     r_mem_a [DEPTH];
  logic [W-1:0]     r_mem_b [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [W-1:0]     r_mult_a;
  logic [W-1:0]     r_mult_b;
  logic [2*W-1:0]   r_res_data;

  logic             w_push;
  logic             w_pop;
  logic             w_not_empty;
  logic             w_timeout;

  // in_ready looks at the count only, so a full FIFO never accepts a push-through.
  assign in_ready    = (r_count < CW'(DEPTH));
  assign w_not_empty = (r_count != '0);
  assign w_push      = in_valid && in_ready;
  assign w_pop       = w_not_empty &&
                       ((r_state == S_IDLE) || ((r_state == S_HOLD) && res_ready));

  // NOTE: FIFO storage has no reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr] <= in_A;
      r_mem_b[r_wr_ptr] <= in_B;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Operands are loaded on the pop edge and held untouched until the next pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mult_a   <= '0;
      r_mult_b   <= '0;
      r_res_data <= '0;
    end else begin
      if (w_pop) begin
        r_mult_a <= r_mem_a[r_rd_ptr];
        r_mult_b <= r_mem_b[r_rd_ptr];
      end
      if ((r_state == S_WAIT) && mult_done) r_res_data <= mult_out;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  // WAIT is only entered one cycle after ISSUE, which masks a done level left from the last op.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_not_empty) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (mult_done)      w_next = S_HOLD;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_HOLD: begin
        if (res_ready) w_next = w_not_empty ? S_ISSUE : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mult_start = 1'b0;
    res_valid  = 1'b0;
    case (r_state)
      S_ISSUE: mult_start = 1'b1;
      S_HOLD:  res_valid  = 1'b1;
      default: ;
    endcase
  end

  assign mult_A   = r_mult_a;
  assign mult_B   = r_mult_b;
  assign res_data = r_res_data;

`ifdef MULT_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);

  logic [TW-1:0] r_tmo_cnt;
  logic          r_err;

  // Counter holds 0 on the first WAIT cycle; err lands on the edge it would reach TMO.
  assign w_timeout = (r_state == S_WAIT) && !mult_done && (r_tmo_cnt == TW'(TMO - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if (r_state == S_ISSUE)     r_tmo_cnt <= '0;
      else if (r_state == S_WAIT) r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mult_feeder.sv
// Directed bench for mult_feeder with a behavioural multiplier of programmable done delay.
// The timeout scenario runs only when MULT_FEEDER_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_mult_feeder;

`ifdef MULT_FEEDER_TIMEOUT_EN
  localparam int TB_TMO = 16;
`else
  localparam int TB_TMO = 64;
`endif

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [7:0]  in_A      = 8'h00;
  logic [7:0]  in_B      = 8'h00;
  logic        mult_start;
  logic [7:0]  mult_A;
  logic [7:0]  mult_B;
  logic        mult_done = 1'b0;
  logic [15:0] mult_out  = 16'h0000;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic        err;

  int checks = 0;
  int errors = 0;

  int   done_delay = 9;
  bit   force_done = 1'b0;
  bit   never_done = 1'b0;
  int   start_cnt  = 0;
  int   m_cnt      = 0;
  bit   err_seen   = 1'b0;
  logic [7:0] m_a = 8'h00;
  logic [7:0] m_b = 8'h00;

  localparam logic [7:0]  FILL_A [5] = '{8'h01, 8'hFF, 8'h03, 8'h0A, 8'h80};
  localparam logic [7:0]  FILL_B [5] = '{8'h02, 8'hFF, 8'hFC, 8'h0A, 8'h01};
  localparam logic [15:0] FILL_P [5] = '{16'h0002, 16'h0001, 16'hFFF4, 16'h0064, 16'hFF80};
  localparam logic [7:0]  CRN_A  [3] = '{8'h80, 8'h7F, 8'h00};
  localparam logic [7:0]  CRN_B  [3] = '{8'h80, 8'hFF, 8'h9C};
  localparam logic [15:0] CRN_P  [3] = '{16'h4000, 16'hFF81, 16'h0000};

  mult_feeder #(.W(8), .DEPTH(4), .TMO(TB_TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_A       (in_A),
    .in_B       (in_B),
    .mult_start (mult_start),
    .mult_A     (mult_A),
    .mult_B     (mult_B),
    .mult_done  (mult_done),
    .mult_out   (mult_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .err        (err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    sa = {{8{a[7]}}, a};
    sb = {{8{b[7]}}, b};
    return sa * sb;
  endfunction

  // Multiplier model: done drops on start, rises done_delay edges later, then holds.
  always @(posedge clk) begin
    if (mult_start) begin
      start_cnt <= start_cnt + 1;
      m_a       <= mult_A;
      m_b       <= mult_B;
      m_cnt     <= done_delay;
      mult_done <= 1'b0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1 && !never_done) begin
        mult_done <= 1'b1;
        mult_out  <= smul(m_a, m_b);
      end
    end else if (force_done) begin
      mult_done <= 1'b1;
    end
  end

  always @(posedge clk) if (err === 1'b1) err_seen <= 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_A     = a;
    in_B     = b;
    while (in_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL push_wait: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input int budget, output logic [15:0] d, output bit got);
    int n = 0;
    while (res_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    got = (res_valid === 1'b1);
    d   = res_data;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0 || mult_start !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready=%b res_valid=%b mult_start=%b err=%b, required 1 0 0 0",
               in_ready, res_valid, mult_start, err);
    end
    checks++;
    if (mult_A !== 8'h00 || mult_B !== 8'h00 || res_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: mult_A=%h mult_B=%h res_data=%h, required 00 00 0000",
               mult_A, mult_B, res_data);
    end
  endtask

  task automatic test_single();
    logic [15:0] d;
    bit got;
    int s0;
    s0 = start_cnt;
    push(8'hFD, 8'h05);
    checks++;
    if (mult_start !== 1'b0) begin
      errors++;
      $display("FAIL single_start_early: mult_start=%b, required 0", mult_start);
    end
    tick();
    checks++;
    if (mult_start !== 1'b1 || mult_A !== 8'hFD || mult_B !== 8'h05) begin
      errors++;
      $display("FAIL single_issue: start=%b A=%h B=%h, required 1 fd 05", mult_start, mult_A, mult_B);
    end
    tick();
    checks++;
    if (mult_start !== 1'b0 || mult_A !== 8'hFD || mult_B !== 8'h05) begin
      errors++;
      $display("FAIL single_wait: start=%b A=%h B=%h, required 0 fd 05", mult_start, mult_A, mult_B);
    end
    wait_res(40, d, got);
    checks++;
    if (!got || d !== 16'hFFF1) begin
      errors++;
      $display("FAIL single_result: valid=%b data=%h, required 1 fff1", got, d);
    end
    repeat (3) tick();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 16'hFFF1) begin
      errors++;
      $display("FAIL single_hold: valid=%b data=%h, required 1 fff1", res_valid, res_data);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || start_cnt - s0 != 1) begin
      errors++;
      $display("FAIL single_accept: valid=%b starts=%0d, required 0 1", res_valid, start_cnt - s0);
    end
  endtask

  task automatic test_fill();
    logic [15:0] d;
    bit got;
    int acc = 0;
    int extra = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_A     = FILL_A[i];
      in_B     = FILL_B[i];
      if (in_ready === 1'b1) acc++;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (acc != 5 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_ready: accepted=%0d in_ready=%b, required 5 0", acc, in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      wait_res(60, d, got);
      checks++;
      if (!got || d !== FILL_P[i]) begin
        errors++;
        $display("FAIL fill_result[%0d]: valid=%b data=%h, required 1 %h", i, got, d, FILL_P[i]);
      end
      if (i == 0) begin
        // Offer a pair while full on the popping edge; it must not get in.
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL fill_full_hold: in_ready=%b, required 0", in_ready);
        end
        in_valid = 1'b1;
        in_A     = 8'h77;
        in_B     = 8'h77;
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      in_valid  = 1'b0;
      if (i < 4) begin
        checks++;
        if (mult_start !== 1'b1 || mult_A !== FILL_A[i+1]) begin
          errors++;
          $display("FAIL back_to_back[%0d]: start=%b A=%h, required 1 %h",
                   i, mult_start, mult_A, FILL_A[i+1]);
        end
      end
      if (i == 0) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL fill_ready_after_pop: in_ready=%b, required 1", in_ready);
        end
      end
    end
    repeat (40) begin
      tick();
      if (res_valid === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL fill_no_push_through: extra result cycles=%0d, required 0", extra);
    end
  endtask

  task automatic test_corners();
    logic [15:0] d;
    bit got;
    for (int i = 0; i < 3; i++) begin
      push(CRN_A[i], CRN_B[i]);
      wait_res(40, d, got);
      checks++;
      if (!got || d !== CRN_P[i]) begin
        errors++;
        $display("FAIL corner[%0d]: valid=%b data=%h, required 1 %h", i, got, d, CRN_P[i]);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
    end
  endtask

  task automatic test_stale_done();
    int n = 0;
    done_delay = 3;
    force_done = 1'b1;
    repeat (3) tick();
    checks++;
    if (mult_done !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL stale_idle: done=%b res_valid=%b, required 1 0", mult_done, res_valid);
    end
    push(8'h02, 8'h03);
    tick();
    checks++;
    if (mult_start !== 1'b1) begin
      errors++;
      $display("FAIL stale_issue: mult_start=%b, required 1", mult_start);
    end
    while (res_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n != 5 || res_data !== 16'h0006) begin
      errors++;
      $display("FAIL stale_capture: cycles=%0d data=%h, required 5 0006", n, res_data);
    end
    res_ready = 1'b1;
    tick();
    res_ready  = 1'b0;
    force_done = 1'b0;
    done_delay = 9;
  endtask

  task automatic test_reset_mid_wait();
    logic [15:0] d;
    bit got;
    int s0;
    int bad = 0;
    s0 = start_cnt;
    push(8'h11, 8'h11);
    push(8'h22, 8'h22);
    push(8'h33, 8'h33);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1 || mult_start !== 1'b0 || mult_A !== 8'h00) begin
      errors++;
      $display("FAIL midreset_state: res_valid=%b in_ready=%b start=%b A=%h, required 0 1 0 00",
               res_valid, in_ready, mult_start, mult_A);
    end
    repeat (40) begin
      tick();
      if (res_valid === 1'b1 || mult_start === 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || start_cnt - s0 != 1) begin
      errors++;
      $display("FAIL midreset_flush: activity cycles=%0d starts=%0d, required 0 1",
               bad, start_cnt - s0);
    end
    push(8'h06, 8'hF9);
    wait_res(40, d, got);
    checks++;
    if (!got || d !== 16'hFFD6) begin
      errors++;
      $display("FAIL midreset_recover: valid=%b data=%h, required 1 ffd6", got, d);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

`ifdef MULT_FEEDER_TIMEOUT_EN
  task automatic test_timeout();
    logic [15:0] d;
    bit got;
    int n = 0;
    never_done = 1'b1;
    push(8'h05, 8'h06);
    push(8'h02, 8'h02);
    checks++;
    if (mult_start !== 1'b1 || mult_A !== 8'h05) begin
      errors++;
      $display("FAIL tmo_issue: start=%b A=%h, required 1 05", mult_start, mult_A);
    end
    while (err !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    never_done = 1'b0;
    checks++;
    if (n != 17 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL tmo_err: cycles=%0d res_valid=%b, required 17 0", n, res_valid);
    end
    tick();
    checks++;
    if (err !== 1'b0 || mult_start !== 1'b1 || mult_A !== 8'h02) begin
      errors++;
      $display("FAIL tmo_next: err=%b start=%b A=%h, required 0 1 02", err, mult_start, mult_A);
    end
    wait_res(40, d, got);
    checks++;
    if (!got || d !== 16'h0004) begin
      errors++;
      $display("FAIL tmo_result: valid=%b data=%h, required 1 0004", got, d);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_corners();
    test_stale_done();
    test_reset_mid_wait();
`ifdef MULT_FEEDER_TIMEOUT_EN
    test_timeout();
`else
    checks++;
    if (err_seen) begin
      errors++;
      $display("FAIL err_tied: err was seen high=%b, required 0", err_seen);
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: run still active at %0t, required finished", $time);
    $fatal(1, "time limit");
  end

endmodule
